// File: rtl/aoc3_pkg.sv
// aoc3_pkg: feeder state encoding and ASCII constants shared by the day-3 line feeder.
// DATA_WIDTH normally comes from common.svh; the guarded default keeps standalone builds working.
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif
package aoc3_pkg;
    typedef enum logic [2:0] {STREAM, DRAIN, CAPTURE, CLEAR, DONE} feeder_state_e;
    localparam logic [7:0] ASC_0  = 8'h30;
    localparam logic [7:0] ASC_9  = 8'h39;
    localparam logic [7:0] ASC_LF = 8'h0A;
    localparam logic [7:0] ASC_CR = 8'h0D;
endpackage

// File: rtl/aoc3_ascii_classify.sv
// aoc3_ascii_classify: combinational byte classifier for the line feeder.
module aoc3_ascii_classify
    import aoc3_pkg::*;
(
    input  logic [7:0] ch,
    output logic       is_digit,
    output logic       is_lf,
    output logic       is_cr,
    output logic [3:0] digit_val
);
    always_comb begin
        is_digit  = (ch >= ASC_0) && (ch <= ASC_9);
        is_lf     = ch == ASC_LF;
        is_cr     = ch == ASC_CR;
        // '0'..'9' sit at 0x30..0x39, so the low nibble is the value
        digit_val = ch[3:0];
    end
endmodule

// File: rtl/aoc3_line_feeder.sv
// aoc3_line_feeder: ASCII byte stream to day-3 solver digit interface with per-line sum.
// Optional illegal-character / runaway-line detection is enabled by AOC3_FEEDER_ERR_EN.
module aoc3_line_feeder
    import aoc3_pkg::*;
#(
    parameter int DRAIN_CYCLES = 12,
    parameter int SUM_WIDTH    = 64,
    parameter int CNT_WIDTH    = 16
) (
    input  logic                       clock,
    input  logic                       reset_n,
    input  logic [7:0]                 char_in,
    input  logic                       char_valid,
    output logic                       char_ready,
    input  logic                       eof,
    output logic [`DATA_WIDTH-1:0]     sol_data,
    output logic                       sol_data_valid,
    output logic                       sol_newline,
    output logic                       sol_reset,
    input  logic [2*`DATA_WIDTH-1:0]   sol_result,
    output logic [SUM_WIDTH-1:0]       cum_sum,
    output logic [CNT_WIDTH-1:0]       line_count,
    output logic                       done,
    output logic                       err_char
);
    localparam int CW = $clog2(DRAIN_CYCLES + 1);

    feeder_state_e state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic has_digit_q, has_digit_d;
    logic eof_pend_q, eof_pend_d;
    logic [`DATA_WIDTH-1:0] data_q, data_d;
    logic dvalid_q, dvalid_d;
    logic newline_q, newline_d;
    logic solrst_q, solrst_d;
    logic ready_q, ready_d;
    logic done_q, done_d;
    logic [SUM_WIDTH-1:0] cum_q, cum_d;
    logic [CNT_WIDTH-1:0] lines_q, lines_d;
    logic is_digit, is_lf, is_cr, acc;
    logic [3:0] digit_val;

    aoc3_ascii_classify u_cls (
        .ch       (char_in),
        .is_digit (is_digit),
        .is_lf    (is_lf),
        .is_cr    (is_cr),
        .digit_val(digit_val)
    );

    assign acc = char_valid && ready_q && (state_q == STREAM);

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        has_digit_d = has_digit_q;
        eof_pend_d  = eof_pend_q;
        data_d      = data_q;
        dvalid_d    = 1'b0;
        cum_d       = cum_q;
        lines_d     = lines_q;
        case (state_q)
            STREAM: begin
                if (acc) begin
                    eof_pend_d = eof_pend_q || eof;
                    if (is_digit) begin
                        dvalid_d    = 1'b1;
                        data_d      = `DATA_WIDTH'(digit_val);
                        has_digit_d = 1'b1;
                    end else if (is_lf && has_digit_q) begin
                        state_d = DRAIN;
                        cnt_d   = CW'(DRAIN_CYCLES - 1);
                    end
                end else if (eof || eof_pend_q) begin
                    // a pending eof with an open line takes an implicit newline first
                    eof_pend_d = 1'b1;
                    state_d    = has_digit_q ? DRAIN : DONE;
                    cnt_d      = CW'(DRAIN_CYCLES - 1);
                end
            end
            DRAIN: begin
                cnt_d   = cnt_q - CW'(1);
                state_d = (cnt_q == '0) ? CAPTURE : DRAIN;
            end
            CAPTURE: begin
                cum_d   = cum_q + SUM_WIDTH'(sol_result);
                lines_d = lines_q + CNT_WIDTH'(1);
                state_d = CLEAR;
            end
            CLEAR: begin
                has_digit_d = 1'b0;
                state_d     = eof_pend_q ? DONE : STREAM;
            end
            DONE:    state_d = DONE;
            default: state_d = STREAM;
        endcase
        ready_d   = state_d == STREAM;
        newline_d = state_d inside {DRAIN, CAPTURE, CLEAR};
        solrst_d  = state_d inside {CLEAR, DONE};
        done_d    = state_d == DONE;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= STREAM;
            cnt_q       <= '0;
            has_digit_q <= 1'b0;
            eof_pend_q  <= 1'b0;
            data_q      <= '0;
            dvalid_q    <= 1'b0;
            newline_q   <= 1'b0;
            solrst_q    <= 1'b1;
            ready_q     <= 1'b0;
            done_q      <= 1'b0;
            cum_q       <= '0;
            lines_q     <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            has_digit_q <= has_digit_d;
            eof_pend_q  <= eof_pend_d;
            data_q      <= data_d;
            dvalid_q    <= dvalid_d;
            newline_q   <= newline_d;
            solrst_q    <= solrst_d;
            ready_q     <= ready_d;
            done_q      <= done_d;
            cum_q       <= cum_d;
            lines_q     <= lines_d;
        end
    end

`ifdef AOC3_FEEDER_ERR_EN
    localparam int MAX_DIGITS = DRAIN_CYCLES * 8;
    localparam int DW = $clog2(MAX_DIGITS + 1);
    logic err_q, err_d;
    logic [DW-1:0] dig_cnt_q, dig_cnt_d;

    always_comb begin
        err_d     = err_q || (acc && !is_digit && !is_lf && !is_cr);
        dig_cnt_d = (state_q == CLEAR) ? '0 : dig_cnt_q;
        if (acc && is_digit) begin
            err_d     = err_d || (dig_cnt_q == DW'(MAX_DIGITS));
            dig_cnt_d = (dig_cnt_q == DW'(MAX_DIGITS)) ? dig_cnt_q : dig_cnt_q + DW'(1);
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            err_q     <= 1'b0;
            dig_cnt_q <= '0;
        end else begin
            err_q     <= err_d;
            dig_cnt_q <= dig_cnt_d;
        end
    end

    assign err_char = err_q;
`else
    logic unused_cr;
    assign unused_cr = is_cr;
    assign err_char  = 1'b0;
`endif

    assign char_ready     = ready_q;
    assign sol_data       = data_q;
    assign sol_data_valid = dvalid_q;
    assign sol_newline    = newline_q;
    assign sol_reset      = solrst_q;
    assign cum_sum        = cum_q;
    assign line_count     = lines_q;
    assign done           = done_q;
endmodule
